// File: rtl/store_rmw_pkg.sv
// Shared state encoding and store-size codes for the store read-modify-write sequencer.
// No timing of its own; no backpressure.
package store_rmw_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_MDR  = 2'b11;

endpackage

// File: rtl/store_data_merge.sv
// Merges the MDR word with register-B data according to store size.
// Purely combinational, zero latency; no backpressure.
module store_data_merge
    import store_rmw_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [31:0] i_mdr,
    input  logic [31:0] i_data,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_data;
        case (i_size)
            SZ_HALF: o_merged = {i_mdr[31:16], i_data[15:0]};
            SZ_BYTE: o_merged = {i_mdr[31:8],  i_data[7:0]};
            SZ_MDR:  o_merged = i_mdr;
            default: o_merged = i_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Sequences SW as one write and SB/SH/refresh as read, MDR capture, merged write.
// Word: write cycle 1, done cycle 2; partial: write MEM_LAT+2, done MEM_LAT+3; start ignored while busy.
module store_rmw_sequencer
    import store_rmw_pkg::*;
#(
    parameter  int MEM_LAT = 1,
    localparam int CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] data_b,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mdr_out,
    output logic        busy,
    output logic        done
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_data;
    logic [31:0]       r_mdr;
    logic [31:0]       w_merged;

    store_data_merge u_merge (
        .i_size   (r_size),
        .i_mdr    (r_mdr),
        .i_data   (r_data),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_size  <= SZ_WORD;
            r_data  <= '0;
            r_mdr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr <= addr;
                        r_size <= size;
                        r_data <= data_b;
                        if (size == SZ_WORD) begin
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                            r_cnt   <= CNT_W'(MEM_LAT - 1);
                        end
                    end
                end
                READ: begin
                    // Read is held for MEM_LAT cycles; data lands the cycle after the last one.
                    if (r_cnt == '0) r_state <= CAPTURE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    r_mdr   <= mem_rdata;
                    r_state <= WRITE;
                end
                WRITE:   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        done      = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            READ, CAPTURE: mem_addr = r_addr;
            WRITE: begin
                mem_addr  = r_addr;
                mem_wr    = 1'b1;
                mem_wdata = w_merged;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign mdr_out = r_mdr;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Drives two sequencers (MEM_LAT=1 and MEM_LAT=3) with shared stimulus and
// compares every output each cycle against a transaction-level timing model.
module tb_store_rmw_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] data_b = '0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] a1_addr, a1_wdata, a1_mdr, a3_addr, a3_wdata, a3_mdr;
    logic        a1_wr, a1_busy, a1_done, a3_wr, a3_busy, a3_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per instance: 0 -> MEM_LAT=1, 1 -> MEM_LAT=3
    bit          m_act [2];
    int          m_t0  [2];
    logic [1:0]  m_sz  [2];
    logic [31:0] m_a   [2];
    logic [31:0] m_d   [2];
    logic [31:0] m_mdr [2];

    always #5 clk = ~clk;

    store_rmw_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
        .data_b(data_b), .mem_rdata(mem_rdata), .mem_addr(a1_addr), .mem_wr(a1_wr),
        .mem_wdata(a1_wdata), .mdr_out(a1_mdr), .busy(a1_busy), .done(a1_done)
    );

    store_rmw_sequencer #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
        .data_b(data_b), .mem_rdata(mem_rdata), .mem_addr(a3_addr), .mem_wr(a3_wr),
        .mem_wdata(a3_wdata), .mdr_out(a3_mdr), .busy(a3_busy), .done(a3_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] mdr, input logic [31:0] d,
                                              input logic [1:0] sz);
        case (sz)
            2'b01:   return (mdr & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            2'b10:   return (mdr & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
            2'b11:   return mdr;
            default: return d;
        endcase
    endfunction

    task automatic check_inst(input int k, input int ml, input logic b, input logic dn,
                              input logic wr, input logic [31:0] ma, input logic [31:0] wd,
                              input logic [31:0] md);
        int rel, lat;
        logic eb, ed, ew;
        logic [31:0] ea, ewd;
        bit use_a, use_wd;
        rel = 0; lat = 0;
        eb = 1'b0; ed = 1'b0; ew = 1'b0; ea = '0; ewd = '0; use_a = 1; use_wd = 1;
        if (m_act[k]) begin
            rel = cyc - m_t0[k];
            lat = (m_sz[k] == 2'b00) ? 1 : ml + 2;
            eb  = 1'b1;
            ew  = (rel == lat);
            ed  = (rel == lat + 1);
            if (ew) begin
                ea  = m_a[k];
                ewd = ref_merge(m_mdr[k], m_d[k], m_sz[k]);
            end else if (!ed) begin
                // read phase drives the address; capture cycle address and data are don't-care
                if (rel <= ml) ea = m_a[k];
                else           use_a = 0;
                use_wd = 0;
            end
        end
        chk($sformatf("L%0d busy", ml), {31'd0, b}, {31'd0, eb});
        chk($sformatf("L%0d done", ml), {31'd0, dn}, {31'd0, ed});
        chk($sformatf("L%0d mem_wr", ml), {31'd0, wr}, {31'd0, ew});
        if (use_a)  chk($sformatf("L%0d mem_addr", ml), ma, ea);
        if (use_wd) chk($sformatf("L%0d mem_wdata", ml), wd, ewd);
        chk($sformatf("L%0d mdr_out", ml), md, m_mdr[k]);

        if (reset) begin
            m_act[k] = 0; m_mdr[k] = '0; m_sz[k] = '0; m_a[k] = '0; m_d[k] = '0;
        end else if (m_act[k]) begin
            if (m_sz[k] != 2'b00 && rel == ml + 1) m_mdr[k] = mem_rdata;
            if (rel == lat + 1) m_act[k] = 0;
        end else if (start) begin
            m_act[k] = 1; m_t0[k] = cyc; m_sz[k] = size; m_a[k] = addr; m_d[k] = data_b;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd);
        @(negedge clk);
        reset = rst; start = st; size = sz; addr = a; data_b = d; mem_rdata = rd;
        #1;
        check_inst(0, 1, a1_busy, a1_done, a1_wr, a1_addr, a1_wdata, a1_mdr);
        check_inst(1, 3, a3_busy, a3_done, a3_wr, a3_addr, a3_wdata, a3_mdr);
        cyc++;
    endtask

    task automatic idle(input int n, input logic [31:0] rd);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, rd);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_t0[k] = 0; m_sz[k] = '0; m_a[k] = '0; m_d[k] = '0; m_mdr[k] = '0;
        end
        step(1'b1, 1'b1, 2'b01, 32'h99, 32'h77, 32'h55);
        step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

        // word store
        step(1'b0, 1'b1, 2'b00, 32'h40, 32'hDEADBEEF, 32'h0);
        idle(8, 32'h0);
        // halfword store
        step(1'b0, 1'b1, 2'b01, 32'h44, 32'hAAAABBBB, 32'h11223344);
        idle(8, 32'h11223344);
        // byte store
        step(1'b0, 1'b1, 2'b10, 32'h48, 32'h000000EE, 32'hCAFEF00D);
        idle(8, 32'hCAFEF00D);
        // MDR refresh, with a second start while busy
        step(1'b0, 1'b1, 2'b11, 32'h4C, 32'h0, 32'h12345678);
        step(1'b0, 1'b1, 2'b00, 32'h50, 32'h13579BDF, 32'h12345678);
        idle(8, 32'h12345678);
        // reset landing on the write cycle of a halfword store (MEM_LAT=1 instance)
        step(1'b0, 1'b1, 2'b01, 32'h60, 32'h0000BEEF, 32'h87654321);
        idle(2, 32'h87654321);
        step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h87654321);
        idle(2, 32'h0);
        step(1'b0, 1'b1, 2'b00, 32'h64, 32'h01020304, 32'h0);
        idle(6, 32'h0);
        // start held high with word stores
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'b00, 32'h100 + i, 32'hA0 + i, 32'h0);
        idle(6, 32'h0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        end
        idle(8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
